// File: rtl/entryconv_seq_ctrl_pkg.sv
// Shared types and default widths for the EntryConv block-level sequencer.
package entryconv_ctrl_pkg;

  // Sequencer phases: wait for host, load child, compute child, completion pulse.
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMP,
    DONE
  } seq_state_e;

  localparam int unsigned TILE_W_DEF = 8;
  localparam int unsigned PERF_W_DEF = 32;

endpackage

// File: rtl/entryconv_seq_ctrl_if.sv
// Host-facing ap_ctrl_hs port plus the two children's start/ready/done bundles.
// The perf counter outputs exist only when ENTRYCONV_SEQ_PERF_EN is defined.
interface entryconv_seq_ctrl_if import entryconv_ctrl_pkg::*; #(
  parameter int unsigned TILE_W = TILE_W_DEF
`ifdef ENTRYCONV_SEQ_PERF_EN
  , parameter int unsigned PERF_W = PERF_W_DEF
`endif
);

  logic              ap_start;
  logic              ap_done;
  logic              ap_ready;
  logic              ap_idle;
  logic [TILE_W-1:0] num_tiles;
  logic [TILE_W-1:0] tile_idx;
  logic              load_ap_start;
  logic              load_ap_ready;
  logic              load_ap_done;
  logic              comp_ap_start;
  logic              comp_ap_ready;
  logic              comp_ap_done;
`ifdef ENTRYCONV_SEQ_PERF_EN
  logic [PERF_W-1:0] perf_load_cyc;
  logic [PERF_W-1:0] perf_comp_cyc;

  // Sequencer side.
  modport master (
    input  ap_start, num_tiles, load_ap_ready, load_ap_done, comp_ap_ready, comp_ap_done,
    output ap_done, ap_ready, ap_idle, tile_idx, load_ap_start, comp_ap_start,
    output perf_load_cyc, perf_comp_cyc
  );

  // Host and children side.
  modport slave (
    output ap_start, num_tiles, load_ap_ready, load_ap_done, comp_ap_ready, comp_ap_done,
    input  ap_done, ap_ready, ap_idle, tile_idx, load_ap_start, comp_ap_start,
    input  perf_load_cyc, perf_comp_cyc
  );
`else
  // Sequencer side.
  modport master (
    input  ap_start, num_tiles, load_ap_ready, load_ap_done, comp_ap_ready, comp_ap_done,
    output ap_done, ap_ready, ap_idle, tile_idx, load_ap_start, comp_ap_start
  );

  // Host and children side.
  modport slave (
    output ap_start, num_tiles, load_ap_ready, load_ap_done, comp_ap_ready, comp_ap_done,
    input  ap_done, ap_ready, ap_idle, tile_idx, load_ap_start, comp_ap_start
  );
`endif

endinterface

// File: rtl/entryconv_seq_ctrl_hs_child_drv.sv
// Per-child ap_ctrl_hs driver: raises ap_start on launch, holds it until the
// child reports ready (or done), and qualifies the child's done with the phase enable.
module hs_child_drv (
  input  logic clk_i,
  input  logic rst_i,
  input  logic launch_i,
  input  logic en_i,
  input  logic ap_ready_i,
  input  logic ap_done_i,
  output logic ap_start_o,
  output logic done_o
);

  logic start_q, start_d;
  logic rdy_seen_q, rdy_seen_d;

  // Start is held only while the phase is active and no ready/done has been seen.
  always_comb begin
    rdy_seen_d = rdy_seen_q;
    if (launch_i) begin
      rdy_seen_d = 1'b0;
    end else if (en_i && ap_ready_i) begin
      rdy_seen_d = 1'b1;
    end
    start_d = launch_i | (start_q & en_i & ~ap_ready_i & ~ap_done_i & ~rdy_seen_q);
  end

  // Handshake state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      start_q    <= 1'b0;
      rdy_seen_q <= 1'b0;
    end else begin
      start_q    <= start_d;
      rdy_seen_q <= rdy_seen_d;
    end
  end

  assign ap_start_o = start_q;
  // A done pulse outside this child's phase is dropped here.
  assign done_o     = en_i & ap_done_i;

endmodule

// File: rtl/entryconv_seq_ctrl.sv
// EntryConv block-level ap_ctrl_hs sequencer: per tile, runs the load child then
// the compute child, num_tiles times, then pulses ap_done/ap_ready.
// Optional feature macro: ENTRYCONV_SEQ_PERF_EN adds saturating per-phase cycle counters.
module entryconv_seq_ctrl import entryconv_ctrl_pkg::*; #(
  parameter int unsigned TILE_W = TILE_W_DEF
`ifdef ENTRYCONV_SEQ_PERF_EN
  , parameter int unsigned PERF_W = PERF_W_DEF
`endif
) (
  input logic                  clock,
  input logic                  reset,
  entryconv_seq_ctrl_if.master bus
);

  seq_state_e        state_q;
  logic [TILE_W-1:0] tiles_q;
  logic [TILE_W-1:0] tile_idx_q;
  logic              done_q;
  logic              idle_q;

  logic load_en, comp_en;
  logic load_launch, comp_launch;
  logic load_done, comp_done;
  logic load_start, comp_start;
  logic last_tile;

  // Phase enables and child launch decode for the coming edge.
  always_comb begin
    load_en     = (state_q == LOAD);
    comp_en     = (state_q == COMP);
    last_tile   = (tile_idx_q == tiles_q - TILE_W'(1));
    load_launch = ((state_q == IDLE) && bus.ap_start && (bus.num_tiles != '0)) ||
                  ((state_q == COMP) && comp_done && !last_tile);
    comp_launch = (state_q == LOAD) && (tiles_q != '0) && load_done;
  end

  hs_child_drv u_load_drv (
    .clk_i      (clock),
    .rst_i      (reset),
    .launch_i   (load_launch),
    .en_i       (load_en),
    .ap_ready_i (bus.load_ap_ready),
    .ap_done_i  (bus.load_ap_done),
    .ap_start_o (load_start),
    .done_o     (load_done)
  );

  hs_child_drv u_comp_drv (
    .clk_i      (clock),
    .rst_i      (reset),
    .launch_i   (comp_launch),
    .en_i       (comp_en),
    .ap_ready_i (bus.comp_ap_ready),
    .ap_done_i  (bus.comp_ap_done),
    .ap_start_o (comp_start),
    .done_o     (comp_done)
  );

  // Sequencer FSM with registered host-side outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tiles_q    <= '0;
      tile_idx_q <= '0;
      done_q     <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.ap_start) begin
            tiles_q    <= bus.num_tiles;
            tile_idx_q <= '0;
            idle_q     <= 1'b0;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          // An empty run passes through LOAD once with the child gated off, so the
          // zero check sees the latched count.
          if (tiles_q == '0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (load_done) begin
            state_q <= COMP;
          end
        end
        COMP: begin
          if (comp_done) begin
            if (last_tile) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              tile_idx_q <= tile_idx_q + TILE_W'(1);
              state_q    <= LOAD;
            end
          end
        end
        DONE: begin
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ap_done       = done_q;
  assign bus.ap_ready      = done_q;
  assign bus.ap_idle       = idle_q;
  assign bus.tile_idx      = tile_idx_q;
  assign bus.load_ap_start = load_start;
  assign bus.comp_ap_start = comp_start;

`ifdef ENTRYCONV_SEQ_PERF_EN
  logic [PERF_W-1:0] perf_load_q;
  logic [PERF_W-1:0] perf_comp_q;

  // Per-phase cycle counters: cleared at run start, saturate, hold after DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_load_q <= '0;
      perf_comp_q <= '0;
    end else if ((state_q == IDLE) && bus.ap_start) begin
      perf_load_q <= '0;
      perf_comp_q <= '0;
    end else begin
      if ((state_q == LOAD) && (perf_load_q != '1)) begin
        perf_load_q <= perf_load_q + PERF_W'(1);
      end
      if ((state_q == COMP) && (perf_comp_q != '1)) begin
        perf_comp_q <= perf_comp_q + PERF_W'(1);
      end
    end
  end

  assign bus.perf_load_cyc = perf_load_q;
  assign bus.perf_comp_cyc = perf_comp_q;
`endif

endmodule

// File: tb/tb_entryconv_seq_ctrl.sv
// Bench for entryconv_seq_ctrl: builds a per-cycle schedule of child responses and
// expected host/child outputs from tile counts and handshake latencies, then replays it.
module tb_entryconv_seq_ctrl;
  import entryconv_ctrl_pkg::*;

  localparam int unsigned TW = TILE_W_DEF;
  localparam int unsigned PW = PERF_W_DEF;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

`ifdef ENTRYCONV_SEQ_PERF_EN
  entryconv_seq_ctrl_if #(.TILE_W(TW), .PERF_W(PW)) bus ();
  entryconv_seq_ctrl #(.TILE_W(TW), .PERF_W(PW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
`else
  entryconv_seq_ctrl_if #(.TILE_W(TW)) bus ();
  entryconv_seq_ctrl #(.TILE_W(TW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
`endif

  // One clock cycle: inputs driven in that cycle and outputs expected in it.
  typedef struct {
    logic          as;
    logic [TW-1:0] nt;
    logic          lr, ld, cr, cd;
    logic [TW+4:0] exp;  // {ap_done, ap_ready, ap_idle, load_start, comp_start, tile_idx}
    logic          pchk;
    logic [PW-1:0] pl, pc;
  } step_t;

  step_t         q[$];
  int            checks = 0;
  int            errors = 0;
  logic [TW-1:0] last_idx = '0;
  logic [PW-1:0] lp = '0;
  logic [PW-1:0] lc = '0;

  function automatic logic [TW+4:0] mk_exp(input logic done, input logic idle,
                                           input logic ls, input logic cs,
                                           input logic [TW-1:0] idx);
    return {done, done, idle, ls, cs, idx};
  endfunction

  function automatic logic nz(input int mode);
    if (mode == 2) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  function automatic void push(input logic as, input logic [TW-1:0] nt, input logic lr,
                               input logic ld, input logic cr, input logic cd,
                               input logic [TW+4:0] exp, input logic pchk);
    step_t s;
    s.as = as; s.nt = nt; s.lr = lr; s.ld = ld; s.cr = cr; s.cd = cd;
    s.exp = exp; s.pchk = pchk; s.pl = lp; s.pc = lc;
    q.push_back(s);
  endfunction

  // Ready at offset lr, done at offset ld of each phase (lr > ld: ready never comes).
  task automatic plan_run(input int n, input bit rnd, input int lr_f, input int ld_f,
                          input int cr_f, input int cd_f, input int noise);
    int lr, ld, cr, cd;
    push(1'b1, TW'(n), 1'b0, 1'b0, 1'b0, 1'b0, mk_exp(1'b0, 1'b1, 1'b0, 1'b0, last_idx), 1'b0);
    lp = '0;
    lc = '0;
    if (n == 0) begin
      push(1'b1, TW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0,
           mk_exp(1'b0, 1'b0, 1'b0, 1'b0, '0), 1'b0);
      lp = 1;
      last_idx = '0;
    end else begin
      for (int t = 0; t < n; t++) begin
        lr = rnd ? int'($urandom_range(0, 7)) : lr_f;
        ld = rnd ? int'($urandom_range(0, 6)) : ld_f;
        cr = rnd ? int'($urandom_range(0, 7)) : cr_f;
        cd = rnd ? int'($urandom_range(0, 6)) : cd_f;
        for (int o = 0; o <= ld; o++) begin
          push(1'b1, TW'($urandom), (o == lr), (o == ld), nz(noise), nz(noise),
               mk_exp(1'b0, 1'b0, (o <= lr), 1'b0, TW'(t)), 1'b0);
          lp = lp + 1;
        end
        for (int o = 0; o <= cd; o++) begin
          push(1'b1, TW'($urandom), nz(noise), nz(noise), (o == cr), (o == cd),
               mk_exp(1'b0, 1'b0, 1'b0, (o <= cr), TW'(t)), 1'b0);
          lc = lc + 1;
        end
      end
      last_idx = TW'(n - 1);
    end
    push(1'b1, TW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0,
         mk_exp(1'b1, 1'b0, 1'b0, 1'b0, last_idx), 1'b1);
  endtask

  task automatic plan_idle(input int k);
    for (int i = 0; i < k; i++) begin
      push(1'b0, TW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0,
           mk_exp(1'b0, 1'b1, 1'b0, 1'b0, last_idx), 1'b1);
    end
  endtask

  task automatic chk(input string tag, input logic [TW+4:0] exp);
    logic [TW+4:0] obs;
    obs = {bus.ap_done, bus.ap_ready, bus.ap_idle, bus.load_ap_start, bus.comp_ap_start,
           bus.tile_idx};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: done/rdy/idle/ls/cs/idx observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive_zero();
    bus.ap_start = 1'b0; bus.num_tiles = '0;
    bus.load_ap_ready = 1'b0; bus.load_ap_done = 1'b0;
    bus.comp_ap_ready = 1'b0; bus.comp_ap_done = 1'b0;
  endtask

  // Replays up to count scheduled cycles (all when count < 0).
  task automatic exec(input string tag, input int count);
    step_t s;
    int    k;
    k = 0;
    while (q.size() != 0 && (count < 0 || k < count)) begin
      s = q.pop_front();
      @(posedge clock);
      #1;
      bus.ap_start = s.as; bus.num_tiles = s.nt;
      bus.load_ap_ready = s.lr; bus.load_ap_done = s.ld;
      bus.comp_ap_ready = s.cr; bus.comp_ap_done = s.cd;
      @(negedge clock);
      chk($sformatf("%s[%0d]", tag, k), s.exp);
`ifdef ENTRYCONV_SEQ_PERF_EN
      if (s.pchk) begin
        checks++;
        assert ({bus.perf_load_cyc, bus.perf_comp_cyc} === {s.pl, s.pc}) else begin
          errors++;
          $error("FAIL perf %s[%0d]: load/comp observed %0d/%0d expected %0d/%0d", tag, k,
                 bus.perf_load_cyc, bus.perf_comp_cyc, s.pl, s.pc);
        end
      end
`endif
      k++;
    end
  endtask

  initial begin
    drive_zero();
    #1 reset = 1'b1;
    #2;
    chk("reset_state", mk_exp(1'b0, 1'b1, 1'b0, 1'b0, '0));
    repeat (2) @(negedge clock);
    reset = 1'b0;

    plan_idle(2);
    exec("idle", -1);

    plan_run(3, 1'b0, 1, 5, 1, 5, 0);
    plan_idle(2);
    exec("three_tiles", -1);

    plan_run(0, 1'b0, 0, 0, 0, 0, 0);
    plan_idle(1);
    exec("zero_tiles", -1);

    // Ready and done together, then a back-to-back run.
    plan_run(2, 1'b0, 3, 3, 0, 0, 0);
    plan_run(1, 1'b0, 0, 2, 1, 1, 0);
    plan_idle(1);
    exec("rdy_done_same", -1);

    plan_run(1, 1'b0, 7, 2, 9, 4, 0);
    plan_idle(1);
    exec("done_no_rdy", -1);

    // The idle child sees ready/done held high throughout the other phase.
    plan_run(2, 1'b0, 2, 4, 1, 3, 2);
    plan_idle(1);
    exec("stray_done", -1);

    plan_run(1, 1'b0, 1, 5, 1, 19, 0);
    plan_idle(2);
    exec("perf_1tile", -1);

    // Reset lands in the compute phase of tile 1 of 4.
    plan_run(4, 1'b0, 1, 5, 1, 5, 0);
    exec("pre_reset", 21);
    q.delete();
    #2 reset = 1'b1;
    #1;
    chk("async_reset", mk_exp(1'b0, 1'b1, 1'b0, 1'b0, '0));
    drive_zero();
    lp = '0;
    lc = '0;
    last_idx = '0;
    @(negedge clock);
    reset = 1'b0;
    plan_run(2, 1'b0, 1, 5, 1, 5, 0);
    plan_idle(1);
    exec("post_reset", -1);

    for (int r = 0; r < 25; r++) begin
      plan_run(int'($urandom_range(0, 4)), 1'b1, 0, 0, 0, 0, int'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) plan_idle(int'($urandom_range(1, 3)));
      exec($sformatf("rand%0d", r), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
